// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// One op in flight, valid/ready on both sides, flush aborts and drops any result.
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter bit HAS_W = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam bit W_OK = HAS_W && (XLEN == 64);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [1:0]        state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] prod_q,   prod_d;
    logic [2*XLEN-1:0] mcand_q,  mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   prem_q,   prem_d;
    logic [XLEN-1:0]   quo_q,    quo_d;
    logic [XLEN-1:0]   dvsr_q,   dvsr_d;
    logic              is_w_q,   is_w_d;
    logic              is_div_q, is_div_d;
    logic              is_rem_q, is_rem_d;
    logic              mul_hi_q, mul_hi_d;
    logic              b_sub_q,  b_sub_d;
    logic              neg_q_q,  neg_q_d;
    logic              neg_r_q,  neg_r_d;

    // Request decode and operand preparation for the accept edge.
    logic            in_w, in_illegal, in_div, in_sgn_div, in_a_signed;
    logic [31:0]     a_w, b_w;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic            a_neg, b_neg, b_zero, ovf, special;
    logic [XLEN-1:0] dividend_res, special_res;

    always_comb begin
        in_w        = op[3] && W_OK;
        in_illegal  = (op[3] && !W_OK) || (op[3] && !op[2] && (op[1:0] != 2'b00));
        in_div      = op[2];
        in_sgn_div  = op[2] && !op[0];
        in_a_signed = !op[3] && (op[1:0] != 2'b11);
        a_w         = srca[31:0];
        b_w         = srcb[31:0];
        if (in_w) begin
            a_ext = in_sgn_div ? sext32(a_w) : XLEN'(a_w);
            b_ext = in_sgn_div ? sext32(b_w) : XLEN'(b_w);
        end else begin
            a_ext = srca;
            b_ext = srcb;
        end
        a_neg  = in_sgn_div && a_ext[XLEN-1];
        b_neg  = in_sgn_div && b_ext[XLEN-1];
        a_mag  = a_neg ? -a_ext : a_ext;
        b_mag  = b_neg ? -b_ext : b_ext;
        b_zero = (b_ext == '0);
        if (in_w)
            ovf = in_sgn_div && (a_w == 32'h8000_0000) && (b_w == 32'hFFFF_FFFF);
        else
            ovf = in_sgn_div && (srca == XMIN) && (&srcb);
        special      = in_illegal || (in_div && (b_zero || ovf));
        // Both divide-by-zero REM and overflow DIV return the (W-extended) dividend.
        dividend_res = in_w ? sext32(a_w) : srca;
        if (in_illegal)
            special_res = '0;
        else if (b_zero)
            special_res = op[1] ? dividend_res : '1;
        else
            special_res = op[1] ? '0 : dividend_res;
    end

    // One iteration of each datapath; only the one matching the op matters.
    logic            last_iter;
    logic [2*XLEN-1:0] addend, prod_nx;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] rem_sub, prem_nx, quo_nx;
    logic [XLEN-1:0] q_fix, r_fix, div_res, mul_res, raw_res, final_res;

    always_comb begin
        last_iter = (cnt_q == CW'(1));
        addend    = mplier_q[0] ? mcand_q : '0;
        // The MSB of a signed multiplier carries negative weight.
        prod_nx   = (last_iter && b_sub_q) ? prod_q - addend : prod_q + addend;
        shifted   = {prem_q, quo_q[XLEN-1]};
        ge        = (shifted >= {1'b0, dvsr_q});
        rem_sub   = shifted[XLEN-1:0] - dvsr_q;
        prem_nx   = ge ? rem_sub : shifted[XLEN-1:0];
        quo_nx    = {quo_q[XLEN-2:0], ge};
        q_fix     = neg_q_q ? -quo_nx : quo_nx;
        r_fix     = neg_r_q ? -prem_nx : prem_nx;
        div_res   = is_rem_q ? r_fix : q_fix;
        mul_res   = mul_hi_q ? prod_nx[2*XLEN-1:XLEN] : prod_nx[XLEN-1:0];
        raw_res   = is_div_q ? div_res : mul_res;
        final_res = is_w_q ? sext32(raw_res[31:0]) : raw_res;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prem_d   = prem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        is_w_d   = is_w_q;
        is_div_d = is_div_q;
        is_rem_d = is_rem_q;
        mul_hi_d = mul_hi_q;
        b_sub_d  = b_sub_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        is_w_d   = in_w;
                        is_div_d = in_div;
                        is_rem_d = op[1];
                        mul_hi_d = !op[3] && (op[1:0] != 2'b00);
                        b_sub_d  = !op[3] && !op[1];
                        neg_q_d  = a_neg ^ b_neg;
                        neg_r_d  = a_neg;
                        prod_d   = '0;
                        if (in_w)
                            mcand_d = (2*XLEN)'(a_w);
                        else if (in_a_signed)
                            mcand_d = (2*XLEN)'($signed(srca));
                        else
                            mcand_d = (2*XLEN)'(srca);
                        mplier_d = in_w ? XLEN'(b_w) : srcb;
                        prem_d   = '0;
                        // W dividends start at the top so 32 steps finish the job.
                        quo_d    = in_w ? (a_mag << (XLEN - 32)) : a_mag;
                        dvsr_d   = b_mag;
                        if (special) begin
                            result_d = special_res;
                            state_d  = ST_DONE;
                        end else begin
                            cnt_d   = in_w ? CW'(32) : CW'(XLEN);
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    prod_d   = prod_nx;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    prem_d   = prem_nx;
                    quo_d    = quo_nx;
                    cnt_d    = cnt_q - CW'(1);
                    if (last_iter) begin
                        result_d = final_res;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prem_q   <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            is_w_q   <= 1'b0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            mul_hi_q <= 1'b0;
            b_sub_q  <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prem_q   <= prem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            is_w_q   <= is_w_d;
            is_div_q <= is_div_d;
            is_rem_q <= is_rem_d;
            mul_hi_q <= mul_hi_d;
            b_sub_q  <= b_sub_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=64, W ops on): vector table plus
// hand-written handshake, flush, input-stability and async-reset sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] srca;
    logic [63:0] srcb;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64), .HAS_W(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;   // clock edges from accept edge until out_valid is seen
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        check_int("in_ready_before_issue", int'(in_ready), 1);
    endtask

    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        op       = o;
        srca     = a;
        srcb     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          seen;
        logic [63:0] saved;

        vecs[0]  = '{"mul_7_m3",      4'd0,  64'd7,                   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64};
        vecs[1]  = '{"mulhu_max_2",   4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'd1,                   64};
        vecs[2]  = '{"div_m20_6",     4'd4,  64'hFFFF_FFFF_FFFF_FFEC, 64'd6,                   64'hFFFF_FFFF_FFFF_FFFD, 64};
        vecs[3]  = '{"rem_m20_6",     4'd6,  64'hFFFF_FFFF_FFFF_FFEC, 64'd6,                   64'hFFFF_FFFF_FFFF_FFFE, 64};
        vecs[4]  = '{"divu_20_6",     4'd5,  64'd20,                  64'd6,                   64'd3,                   64};
        vecs[5]  = '{"remu_20_6",     4'd7,  64'd20,                  64'd6,                   64'd2,                   64};
        vecs[6]  = '{"divu_by0",      4'd5,  64'd123,                 64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 0};
        vecs[7]  = '{"rem_ovf",       4'd6,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   0};
        vecs[8]  = '{"divw_ovf",      4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0};
        vecs[9]  = '{"mulw",          4'd8,  64'h0000_0001_0000_0003, 64'h0000_0000_4000_0000, 64'hFFFF_FFFF_C000_0000, 32};
        vecs[10] = '{"remuw",         4'd15, 64'h0000_0000_FFFF_FFFF, 64'd2,                   64'd1,                   32};
        vecs[11] = '{"illegal10",     4'd10, 64'd55,                  64'd66,                  64'd0,                   0};
        vecs[12] = '{"mul_big",       4'd0,  64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0001, 64};
        vecs[13] = '{"mulhu_big",     4'd3,  64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'd1,                   64};
        vecs[14] = '{"mulh_min_min",  4'd1,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64};
        vecs[15] = '{"mulhsu_m1_2",   4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[16] = '{"mulh_m1_m1",    4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   64};
        vecs[17] = '{"rem_by0",       4'd6,  64'd5,                   64'd0,                   64'd5,                   0};
        vecs[18] = '{"remuw_by0",     4'd15, 64'hABCD_0000_8000_0005, 64'h1234_0000_0000_0000, 64'hFFFF_FFFF_8000_0005, 0};
        vecs[19] = '{"divw_m7_2",     4'd12, 64'h1234_5678_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 32};
        vecs[20] = '{"divuw_max_1",   4'd13, 64'h0000_0000_FFFF_FFFF, 64'h0000_0005_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 32};
        vecs[21] = '{"div_ovf",       4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0};
        vecs[22] = '{"illegal9",      4'd9,  64'd1,                   64'd1,                   64'd0,                   0};
        vecs[23] = '{"illegal11",     4'd11, 64'd7,                   64'd0,                   64'd0,                   0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        op        = 4'd0;
        srca      = '0;
        srcb      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check64("reset_result", result, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            wait_ready();
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check64({vecs[i].name, "_result"}, result, vecs[i].exp);
            check_int({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            $display("[TB] %s op=%0d a=%h b=%h result=%h out_valid at T+%0d",
                     vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, result, lat + 1);
            consume();
        end

        // Hold result while the consumer stalls, then try a same-cycle re-accept.
        wait_ready();
        issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_int("hold_out_valid", int'(out_valid), 1);
            check64("hold_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
            check_int("hold_in_ready", int'(in_ready), 0);
        end
        $display("[TB] hold: result=%h held for 10 stalled cycles", result);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 4'd5;
        srca      = 64'd20;
        srcb      = 64'd6;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_int("b2b_in_ready", int'(in_ready), 1);
        check_int("b2b_out_valid", int'(out_valid), 0);
        tick();
        check_int("b2b_not_accepted", int'(in_ready), 1);
        $display("[TB] back-to-back: accept with out_ready rejected, in_ready=%0d", in_ready);

        // Flush in the fifth BUSY cycle, with a competing request.
        issue(4'd5, 64'd20, 64'd6);
        repeat (4) tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = 4'd0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_int("flush_in_ready", int'(in_ready), 1);
        check_int("flush_out_valid", int'(out_valid), 0);
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_int("flush_no_result", int'(seen), 0);
        $display("[TB] flush: aborted divu in BUSY cycle 5, out_valid seen=%0d", seen);

        // Operand and opcode changes after accept must not matter.
        wait_ready();
        issue(4'd5, 64'd20, 64'd6);
        srca = 64'd100;
        srcb = 64'd1;
        op   = 4'd0;
        wait_valid(lat);
        check64("stable_result", result, 64'd3);
        check_int("stable_latency", lat, 64);
        $display("[TB] stability: divu 20/6 with inputs changed in BUSY result=%h", result);
        consume();

        // Asynchronous reset in the middle of BUSY, with a nonzero held result.
        wait_ready();
        issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        repeat (3) tick();
        check_int("pre_reset_busy", int'(in_ready), 0);
        #2;
        saved   = result;
        reset_n = 1'b0;
        #1;
        check_int("areset_in_ready", int'(in_ready), 1);
        check_int("areset_out_valid", int'(out_valid), 0);
        check64("areset_result", result, 64'd0);
        $display("[TB] async reset mid-BUSY: result %h -> %h without a clock edge", saved, result);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        wait_ready();
        issue(4'd7, 64'd20, 64'd6);
        wait_valid(lat);
        check64("post_reset_result", result, 64'd2);
        check_int("post_reset_latency", lat, 64);
        $display("[TB] post-reset remu 20/6 result=%h", result);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative integer multiply/divide unit for the execute stage; sits beside the combinational ALU and handles the RV64M operations it lacks.
- Parametrised in data width, with optional 32-bit "W" variants.
- Accepts one operation at a time over a valid/ready handshake and holds its result until the pipeline consumes it.
- A flush input aborts in-flight work on pipeline redirect.

Parameters:
- XLEN, 64: operand/result width; legal values 32 or 64.
- HAS_W, 1: enables the W ops. Only legal when XLEN=64; when 0, W opcodes are treated as illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- op  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW. Codes 9–11 are illegal.
- srca  in  XLEN  rs1 operand.
- srcb  in  XLEN  rs2 operand.
- flush  in  1  abort current op and discard any pending result.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  result value.

Behaviour:
- **Reset:** state IDLE, in_ready=1, out_valid=0, result=0; all internal registers cleared. reset_n low mid-operation aborts immediately and asynchronously.
- **States:**
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- **Accept (IDLE):** in_valid&&in_ready at edge T latches op, srca and srcb.
  - Special case detected: go to DONE (out_valid at T+1).
  - Otherwise: go to BUSY with counter N (N=XLEN; N=32 for W ops).
- **Iteration:**
  - Multiply: radix-2 shift-add on a 2·XLEN product. Operands are sign/zero-extended according to op, so MULH, MULHSU and MULHU are exact.
  - Divide: restoring algorithm on magnitudes, with quotient/remainder sign fixup applied on the final cycle.
  - One iteration per cycle; the counter decrements each cycle. When the counter hits 0, go to DONE; out_valid is first high at T+N+1.
- **Result selection:**
  - MUL: low half of the product.
  - MULH, MULHSU, MULHU: high half of the product.
  - W ops: operate on bits [31:0]; result = sign-extend of the 32-bit result to XLEN, including DIVUW and REMUW.
- **Special cases (1-cycle path):**
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU result = dividend (W ops: sign-extended srca[31:0]).
  - Signed overflow (dividend = most-negative, divisor = −1): DIV quotient = dividend; REM result = 0. Checked at width 32 for W ops.
  - Illegal op: result = 0, 1-cycle path.
- **DONE:**
  - result is held stable while out_valid && !out_ready.
  - out_ready at edge → IDLE, and in_ready=1 in the next cycle. There is no same-cycle result-to-accept bypass, so back-to-back throughput is at best one op per 2 cycles.
- **Flush:** in any state, flush at the edge → IDLE with out_valid=0.
  - flush has priority over accept, iteration and out_ready.
  - in_valid in a flush cycle is ignored.
- **Input stability:** inputs are sampled only at the accept edge; changes to srca, srcb or op during BUSY have no effect.
- **Width rule:** all arithmetic is modulo 2^XLEN except the internal 2·XLEN product and the XLEN+1 partial remainder.

Test Plan:
- XLEN=64, MUL with srca=7, srcb=−3 (0xFFFF_FFFF_FFFF_FFFD) → out_valid at T+65, result 0xFFFF_FFFF_FFFF_FFEB. Then MULHU with 0xFFFF_FFFF_FFFF_FFFF × 2 → result 1.
- DIV with srca=−20, srcb=6 → result −3; REM on the same operands → −2; DIVU with srca=20, srcb=6 → 3; REMU on the same operands → 2. Each op takes 65 cycles.
- Special cases:
  - DIVU with srcb=0 → result all ones at T+1.
  - REM with srca=0x8000_0000_0000_0000, srcb=−1 → result 0 at T+1.
  - DIVW with srca=0x8000_0000, srcb=0xFFFF_FFFF → result 0xFFFF_FFFF_8000_0000.
- W ops:
  - MULW with srca=0x1_0000_0003, srcb=0x4000_0000 → result 0xFFFF_FFFF_C000_0000, out_valid at T+33.
  - REMUW with srca=0xFFFF_FFFF, srcb=2 → result 1.
- Handshake:
  - Hold out_ready=0 for 10 cycles → result and out_valid stay stable.
  - Pulse flush in BUSY cycle 5 → IDLE next cycle, no out_valid.
  - Assert reset_n low mid-BUSY → outputs return to reset values without a clock edge.
- Illegal op 10 → result 0 at T+1. A back-to-back accept attempt in the same cycle as out_ready is rejected (in_ready=0).
